// File: rtl/huc_pkg.sv
// Shared types and constants for the banked HuCard mapper.
// Bus structs are sized for BANK_W up to 4 (ROM address space up to 16 MB).
package huc_pkg;

    localparam int MEM_AW = 24;

    localparam logic [20:0] REG_BASE_DFLT = 21'h001FF0;

    localparam logic [1:0] REG_ROM0 = 2'd0;
    localparam logic [1:0] REG_ROMB = 2'd1;
    localparam logic [1:0] REG_RAM  = 2'd2;

    localparam logic [3:0] KEY_OFF = 4'h8;
    localparam logic [7:0] KEY_A   = 8'hA5;
    localparam logic [7:0] KEY_B   = 8'h5A;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        KEY1     = 2'd1,
        UNLOCKED = 2'd2
    } lk_state_t;

    typedef struct packed {
        logic [20:0] addr;
        logic [7:0]  data;
        logic        oe;
        logic        we;
    } cpu_bus_t;

    typedef struct packed {
        logic [7:0]        dati;
        logic [MEM_AW-1:0] addr;
        logic              ce;
        logic              oe;
        logic              we;
    } mem_ctrl_t;

endpackage

// File: rtl/huc_unlock.sv
// Save-RAM write-unlock sequencer: A5 then 5A at the key offset unlocks, 00 relocks.
// Latency: wr_en reflects a key write from the next cycle; no backpressure, stb is one cycle per write.
module huc_unlock
    import huc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       stb,
    input  logic [3:0] off,
    input  logic [7:0] data,
    output logic       wr_en
);

    lk_state_t state;
    lk_state_t state_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOCKED;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (stb) begin
            if (off == KEY_OFF) begin
                case (state)
                    LOCKED:   state_nx = (data == KEY_A) ? KEY1 : LOCKED;
                    KEY1:     state_nx = (data == KEY_B) ? UNLOCKED : LOCKED;
                    UNLOCKED: state_nx = (data == 8'h00) ? LOCKED : UNLOCKED;
                    default:  state_nx = LOCKED;
                endcase
            end else if (state == KEY1) begin
                // the two key bytes must arrive back to back
                state_nx = LOCKED;
            end
        end
    end

    assign wr_en = (state == UNLOCKED);

endmodule

// File: rtl/huc_bank.sv
// Banked HuCard mapper: fixed ROM bank 0, switchable 512 KB ROM window, lockable save RAM.
// Decode is combinational (zero latency); register writes take effect the cycle after the we edge; no backpressure.
module huc_bank
    import huc_pkg::*;
#(
    parameter int          BANK_W    = 2,
    parameter int          BANK_MODE = 0,
    parameter int          RAM_EN    = 1,
    parameter int          RAM_AW    = 15,
    parameter int          RAM_LOCK  = 1,
    parameter logic [20:0] REG_BASE  = REG_BASE_DFLT
) (
    input  logic       clk,
    input  logic       rst,
    input  cpu_bus_t   cpu,
    input  logic [7:0] rom_dato,
    input  logic [7:0] ram_dato,
    output mem_ctrl_t  rom,
    output mem_ctrl_t  ram,
    output logic       cart_ce,
    output logic [7:0] cart_dato
);

    logic [1:0]        region;
    logic [3:0]        off;
    logic              we_q;
    logic              wr_stb;
    logic              reg_hit;
    logic              bank_hit;
    logic [BANK_W-1:0] bank_q;
    logic [BANK_W:0]   eff_bank;
    logic              lk_wr_en;
    logic              wr_en;
    logic              rom_ce;
    logic              ram_ce;

    assign region  = cpu.addr[20:19];
    assign off     = cpu.addr[3:0];
    assign wr_stb  = cpu.we & ~we_q;
    assign reg_hit = wr_stb && (cpu.addr[20:4] == REG_BASE[20:4]);

    // narrow banks decode only offsets 0-3; wider ones need offsets 0-7
    assign bank_hit = (BANK_MODE != 0) ? (off == 4'h0)
                    : (BANK_W <= 2)    ? (off[3:2] == 2'b00)
                    :                    !off[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            bank_q <= '0;
        end else begin
            we_q <= cpu.we;
            if (reg_hit && bank_hit) begin
                bank_q <= (BANK_MODE != 0) ? cpu.data[BANK_W-1:0] : BANK_W'(off);
            end
        end
    end

    huc_unlock u_unlock (
        .clk   (clk),
        .rst   (rst),
        .stb   (reg_hit),
        .off   (off),
        .data  (cpu.data),
        .wr_en (lk_wr_en)
    );

    assign wr_en = (RAM_LOCK != 0) ? lk_wr_en : 1'b1;

    // window slot is bank_q+1 so bank 0 of the window never aliases the fixed region
    assign eff_bank = (region == REG_ROMB) ? ({1'b0, bank_q} + (BANK_W+1)'(1)) : '0;

    assign rom_ce = (region == REG_ROM0) || (region == REG_ROMB);
    assign ram_ce = (RAM_EN != 0) && (region == REG_RAM);

    always_comb begin
        rom      = '0;
        rom.dati = cpu.data;
        rom.addr = MEM_AW'({eff_bank, cpu.addr[18:0]});
        rom.ce   = rom_ce;
        rom.oe   = cpu.oe;
        rom.we   = 1'b0;

        ram      = '0;
        ram.dati = cpu.data;
        ram.addr = MEM_AW'(cpu.addr[RAM_AW-1:0]);
        ram.ce   = ram_ce;
        ram.oe   = cpu.oe;
        ram.we   = cpu.we & ram_ce & wr_en;
    end

    assign cart_ce   = rom_ce | ram_ce;
    assign cart_dato = rom_ce ? rom_dato : ram_dato;

endmodule

// File: tb/tb_huc_bank.sv
// Scoreboard bench for huc_bank: one address-latched (BANK_W=2) and one data-latched (BANK_W=3) instance.
module tb_huc_bank;
    import huc_pkg::*;

    localparam int S_ROM_ADDR0  = 0;
    localparam int S_CART_CE0   = 1;
    localparam int S_ROM_WE0    = 2;
    localparam int S_RAM_WE0    = 3;
    localparam int S_RAM_ADDR0  = 4;
    localparam int S_CART_DATO0 = 5;
    localparam int S_RAM_CE0    = 6;
    localparam int S_ROM_ADDR1  = 7;
    localparam int S_ROM_WE1    = 8;

    logic       clk = 1'b0;
    logic       rst;
    cpu_bus_t   cpu0, cpu1;
    logic [7:0] rom_dato, ram_dato;
    mem_ctrl_t  rom0, ram0, rom1, ram1;
    logic       cart_ce0, cart_ce1;
    logic [7:0] cart_dato0, cart_dato1;

    always #5 clk = ~clk;

    huc_bank u_dut0 (
        .clk(clk), .rst(rst), .cpu(cpu0), .rom_dato(rom_dato), .ram_dato(ram_dato),
        .rom(rom0), .ram(ram0), .cart_ce(cart_ce0), .cart_dato(cart_dato0)
    );

    huc_bank #(.BANK_W(3), .BANK_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .cpu(cpu1), .rom_dato(rom_dato), .ram_dato(ram_dato),
        .rom(rom1), .ram(ram1), .cart_ce(cart_ce1), .cart_dato(cart_dato1)
    );

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int s);
        case (s)
            S_ROM_ADDR0:  return 32'(rom0.addr);
            S_CART_CE0:   return 32'(cart_ce0);
            S_ROM_WE0:    return 32'(rom0.we);
            S_RAM_WE0:    return 32'(ram0.we);
            S_RAM_ADDR0:  return 32'(ram0.addr);
            S_CART_DATO0: return 32'(cart_dato0);
            S_RAM_CE0:    return 32'(ram0.ce);
            S_ROM_ADDR1:  return 32'(rom1.addr);
            S_ROM_WE1:    return 32'(rom1.we);
            default:      return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // drive one bus cycle just after the rising edge
    task automatic drive(input int d, input logic [20:0] a, input logic [7:0] dat, input logic we);
        @(posedge clk);
        #1;
        if (d == 0) begin
            cpu0.addr = a; cpu0.data = dat; cpu0.we = we; cpu0.oe = ~we;
        end else begin
            cpu1.addr = a; cpu1.data = dat; cpu1.we = we; cpu1.oe = ~we;
        end
    endtask

    // sample mid-cycle and compare everything queued for this cycle
    task automatic settle();
        exp_t e;
        #2;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sig), e.exp);
        end
    endtask

    task automatic rd(input int d, input logic [20:0] a);
        drive(d, a, 8'h00, 1'b0);
        settle();
    endtask

    task automatic wr(input int d, input logic [20:0] a, input logic [7:0] dat);
        drive(d, a, dat, 1'b1);
        settle();
        drive(d, 21'h180000, 8'h00, 1'b0);
        settle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        cpu0     = '0;
        cpu1     = '0;
        rom_dato = 8'h3C;
        ram_dato = 8'hC3;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // reset state and region decode
        push("rst_rom0_addr", S_ROM_ADDR0, 32'h000100);
        push("rst_rom0_ce", S_CART_CE0, 32'd1);
        push("rom_dato_sel", S_CART_DATO0, 32'h3C);
        rd(0, 21'h000100);
        push("rst_win_addr", S_ROM_ADDR0, 32'h080100);
        rd(0, 21'h080100);
        push("unmapped_ce", S_CART_CE0, 32'd0);
        rd(0, 21'h180000);
        push("rst_win_addr_m1", S_ROM_ADDR1, 32'h080100);
        rd(1, 21'h080100);
        push("ram_ce", S_RAM_CE0, 32'd1);
        push("ram_cart_ce", S_CART_CE0, 32'd1);
        push("ram_dato_sel", S_CART_DATO0, 32'hC3);
        rd(0, 21'h100000);

        // address-latched bank select
        push("bank_wr_rom_we", S_ROM_WE0, 32'd0);
        wr(0, 21'h001FF2, 8'hFF);
        push("bank2_addr", S_ROM_ADDR0, 32'h180010);
        rd(0, 21'h080010);
        push("regpage_rd_addr", S_ROM_ADDR0, 32'h001FF0);
        push("regpage_rd_dato", S_CART_DATO0, 32'h3C);
        rd(0, 21'h001FF0);

        // data-latched bank select, we held for 4 cycles with data changing
        push("bank_hold_rom_we", S_ROM_WE1, 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 21'h001FF0, (i == 0) ? 8'h05 : 8'h02, 1'b1);
            settle();
        end
        drive(1, 21'h180000, 8'h00, 1'b0);
        settle();
        push("bank5_top_addr", S_ROM_ADDR1, 32'h37FFFF);
        rd(1, 21'h0FFFFF);

        // save-RAM lock
        push("locked_ram_we", S_RAM_WE0, 32'd0);
        wr(0, 21'h100004, 8'h77);
        wr(0, 21'h001FF8, 8'hA5);
        wr(0, 21'h001FF8, 8'h5A);
        push("unlocked_ram_we", S_RAM_WE0, 32'd1);
        push("unlocked_ram_addr", S_RAM_ADDR0, 32'h0004);
        wr(0, 21'h100004, 8'h77);
        push("mirror_ram_we", S_RAM_WE0, 32'd1);
        push("mirror_ram_addr", S_RAM_ADDR0, 32'h4004);
        wr(0, 21'h10C004, 8'h11);
        wr(0, 21'h001FF8, 8'h00);
        push("relocked_ram_we", S_RAM_WE0, 32'd0);
        wr(0, 21'h100004, 8'h77);

        // interrupted key sequence stays locked
        wr(0, 21'h001FF8, 8'hA5);
        wr(0, 21'h001FF0, 8'h00);
        wr(0, 21'h001FF8, 8'h5A);
        push("broken_seq_ram_we", S_RAM_WE0, 32'd0);
        wr(0, 21'h100004, 8'h77);

        // reset while unlocked with bank 3
        wr(0, 21'h001FF8, 8'hA5);
        wr(0, 21'h001FF8, 8'h5A);
        wr(0, 21'h001FF3, 8'h00);
        push("bank3_addr", S_ROM_ADDR0, 32'h200000);
        rd(0, 21'h080000);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        push("post_rst_bank", S_ROM_ADDR0, 32'h080000);
        rd(0, 21'h080000);
        push("post_rst_ram_we", S_RAM_WE0, 32'd0);
        wr(0, 21'h100004, 8'h77);

        // we held through reset yields exactly one strobe afterwards
        drive(0, 21'h001FF1, 8'h00, 1'b1);
        rst = 1'b1;
        settle();
        @(posedge clk);
        #1 rst = 1'b0;
        settle();
        drive(0, 21'h180000, 8'h00, 1'b0);
        settle();
        push("held_we_stb_bank", S_ROM_ADDR0, 32'h100000);
        rd(0, 21'h080000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
